// File: rtl/debug_display_sel_pkg.sv
// Shared definitions for the debug display selector: debounce FSM encoding,
// display mode codes and the display source mux.
package debug_display_sel_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } deb_state_t;

    localparam logic [1:0] MODE_PC    = 2'd0;
    localparam logic [1:0] MODE_INSTR = 2'd1;
    localparam logic [1:0] MODE_ALU   = 2'd2;
    localparam logic [1:0] MODE_STEP  = 2'd3;

    // Mode 3 packs the step count above the low half of the write data.
    function automatic logic [31:0] select_display(
        input logic [1:0]  mode,
        input logic [31:0] pc,
        input logic [31:0] instr,
        input logic [31:0] alu_result,
        input logic [15:0] step_count,
        input logic [15:0] mem_lo
    );
        case (mode)
            MODE_PC:    return pc;
            MODE_INSTR: return instr;
            MODE_ALU:   return alu_result;
            default:    return {step_count, mem_lo};
        endcase
    endfunction

endpackage

// File: rtl/debug_display_sel_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a debounce FSM
// that emits exactly one pulse per accepted press.
module btn_debounce
    import debug_display_sel_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Any level change during a check window aborts back to the stable state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync_q2) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!sync_q2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync_q2) begin
                        state <= REL_CHK;
                        cnt   <= '0;
                    end
                end
                REL_CHK: begin
                    if (sync_q2) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // The pulse coincides with the final PRESS_CHK cycle; the consumer registers it.
    assign press_pulse = (state == PRESS_CHK) && sync_q2 && (cnt == CNT_LAST);

endmodule

// File: rtl/debug_display_sel.sv
// Front end for the seven-segment driver: debounced step/mode buttons, CPU
// step enable, step counter and the registered display word.
module debug_display_sel
    import debug_display_sel_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        btn_mode,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_wdata,
    output logic        step_en,
    output logic [1:0]  mode,
    output logic [15:0] step_count,
    output logic [31:0] display
);

    logic step_pulse;
    logic mode_pulse;
    logic unused_wdata_hi;

    assign unused_wdata_hi = ^mem_wdata[31:16];

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_step),
        .press_pulse (step_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_mode),
        .press_pulse (mode_pulse)
    );

    // The counter advances on the same edge that raises step_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_en    <= 1'b0;
            step_count <= 16'h0000;
        end else begin
            step_en <= step_pulse;
            if (step_pulse) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode <= MODE_PC;
        end else if (mode_pulse) begin
            mode <= mode + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            display <= 32'h0000_0000;
        end else begin
            display <= select_display(mode, pc, instr, alu_result, step_count, mem_wdata[15:0]);
        end
    end

endmodule

// File: tb/tb_debug_display_sel.sv
// Self-checking bench for debug_display_sel with a short debounce window.
module tb_debug_display_sel;
    import debug_display_sel_pkg::*;

    localparam int DEB = 4;
    localparam int LAT = 2 + DEB + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_step = 1'b0;
    logic        btn_mode = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] mem_wdata = '0;
    logic        step_en;
    logic [1:0]  mode;
    logic [15:0] step_count;
    logic [31:0] display;

    debug_display_sel #(.DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_mode   (btn_mode),
        .pc         (pc),
        .instr      (instr),
        .alu_result (alu_result),
        .mem_wdata  (mem_wdata),
        .step_en    (step_en),
        .mode       (mode),
        .step_count (step_count),
        .display    (display)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    exp_t        step_q[$];
    exp_t        mode_q[$];
    vec_t        vecs[8];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_steps = '0;
    logic [1:0]  exp_mode = '0;
    logic [1:0]  mode_before;
    bit          mon_en = 1'b0;
    logic        prev_step_en = 1'b0;
    logic [1:0]  prev_mode = '0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        pc         = v.pc;
        instr      = v.instr;
        alu_result = v.alu;
        mem_wdata  = v.wdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en   = 1'b0;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        rst      = 1'b0;
        #1;
        check_output("reset_step_en", 32'(step_en), 32'd0);
        check_output("reset_mode", 32'(mode), 32'd0);
        check_output("reset_step_count", 32'(step_count), 32'd0);
        check_output("reset_display", display, 32'd0);
        step_q.delete();
        mode_q.delete();
        exp_steps = '0;
        exp_mode  = '0;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    // A press is accepted LAT cycles after the first edge that samples it.
    task automatic press(input bit do_step, input bit do_mode, input int hold, input int gap);
        @(negedge clk);
        if (do_step) begin
            exp_steps = exp_steps + 16'd1;
            step_q.push_back('{cyc + LAT, exp_steps});
            btn_step = 1'b1;
        end
        if (do_mode) begin
            exp_mode = exp_mode + 2'd1;
            mode_q.push_back('{cyc + LAT, {14'd0, exp_mode}});
            btn_mode = 1'b1;
        end
        repeat (hold) @(negedge clk);
        btn_step = 1'b0;
        btn_mode = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Scoreboard: every observed step pulse or mode change pops an expectation.
    always @(negedge clk) begin
        exp_t es;
        exp_t em;
        if (mon_en) begin
            if (step_en) begin
                check_output("step_en_not_consecutive", 32'(prev_step_en), 32'd0);
                check_output("step_expected_pending", 32'(step_q.size() != 0), 32'd1);
                if (step_q.size() != 0) begin
                    es = step_q.pop_front();
                    check_output("step_en_cycle", 32'(cyc), 32'(es.due));
                    check_output("step_count_at_pulse", 32'(step_count), 32'(es.val));
                end
            end
            if (mode != prev_mode) begin
                check_output("mode_expected_pending", 32'(mode_q.size() != 0), 32'd1);
                if (mode_q.size() != 0) begin
                    em = mode_q.pop_front();
                    check_output("mode_change_cycle", 32'(cyc), 32'(em.due));
                    check_output("mode_value", 32'(mode), 32'(em.val[1:0]));
                end
            end
        end
        prev_step_en = step_en;
        prev_mode    = mode;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{MODE_PC,    32'h0000_0040, 32'h2008_0005, 32'h0000_000A, 32'h1234_BEEF, 32'h0000_0040};
        vecs[1] = '{MODE_PC,    32'hFFFF_FFFC, 32'h2008_0005, 32'h0000_000A, 32'h1234_BEEF, 32'hFFFF_FFFC};
        vecs[2] = '{MODE_INSTR, 32'h0000_0040, 32'h2008_0005, 32'h0000_000A, 32'h1234_BEEF, 32'h2008_0005};
        vecs[3] = '{MODE_ALU,   32'h0000_0040, 32'h2008_0005, 32'h0000_000A, 32'h1234_BEEF, 32'h0000_000A};
        vecs[4] = '{MODE_ALU,   32'h0000_0040, 32'h2008_0005, 32'hDEAD_BEEF, 32'h1234_BEEF, 32'hDEAD_BEEF};
        vecs[5] = '{MODE_STEP,  32'h0000_0040, 32'h2008_0005, 32'h0000_000A, 32'h1234_BEEF, 32'h0000_BEEF};
        vecs[6] = '{MODE_STEP,  32'h0000_0040, 32'h2008_0005, 32'h0000_000A, 32'hFFFF_5A5A, 32'h0000_5A5A};
        vecs[7] = '{MODE_PC,    32'h0000_0040, 32'h2008_0005, 32'h0000_000A, 32'h1234_BEEF, 32'h0000_0040};

        do_reset();

        // Long hold yields a single pulse.
        press(1'b1, 1'b0, 20, 10);
        check_output("held_step_count", 32'(step_count), 32'd1);

        // Short glitches never reach the end of the press window.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            btn_step = 1'b1;
            repeat (3) @(negedge clk);
            btn_step = 1'b0;
            repeat (5) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_output("glitch_step_count", 32'(step_count), 32'd0);

        for (int i = 0; i < 8; i++) begin
            while (exp_mode != vecs[i].mode) press(1'b0, 1'b1, 9, 10);
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output($sformatf("display_vec%0d", i), display, vecs[i].exp);
        end

        // Counter wrap in mode 3, starting just below the limit.
        while (exp_mode != MODE_STEP) press(1'b0, 1'b1, 9, 10);
        @(negedge clk);
        mem_wdata = 32'hCAFE_0123;
        force dut.step_count = 16'hFFFE;
        @(negedge clk);
        release dut.step_count;
        exp_steps = 16'hFFFE;
        @(negedge clk);
        check_output("wrap_preload_display", display, 32'hFFFE_0123);
        press(1'b1, 1'b0, 9, 10);
        check_output("wrap_ffff_display", display, 32'hFFFF_0123);
        @(negedge clk);
        btn_step  = 1'b1;
        exp_steps = exp_steps + 16'd1;
        step_q.push_back('{cyc + LAT, exp_steps});
        repeat (LAT) @(negedge clk);
        check_output("wrap_step_count", 32'(step_count), 32'd0);
        check_output("wrap_display_lag", 32'(display[31:16]), 32'h0000_FFFF);
        @(negedge clk);
        check_output("wrap_display", display, 32'h0000_0123);
        btn_step = 1'b0;
        repeat (10) @(negedge clk);

        // Simultaneous presses take effect on the same edge.
        @(negedge clk);
        mode_before = mode;
        btn_step  = 1'b1;
        btn_mode  = 1'b1;
        exp_steps = exp_steps + 16'd1;
        exp_mode  = exp_mode + 2'd1;
        step_q.push_back('{cyc + LAT, exp_steps});
        mode_q.push_back('{cyc + LAT, {14'd0, exp_mode}});
        repeat (LAT - 1) @(negedge clk);
        check_output("both_pre_step_en", 32'(step_en), 32'd0);
        check_output("both_pre_mode", 32'(mode), 32'(MODE_STEP));
        @(negedge clk);
        check_output("both_step_en", 32'(step_en), 32'd1);
        check_output("both_mode", 32'(mode), 32'(MODE_PC));
        check_output("both_step_count", 32'(step_count), 32'd1);
        repeat (2) @(negedge clk);
        btn_step = 1'b0;
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);
        press(1'b0, 1'b1, 9, 10);

        // Reset lands while the step press is mid-check (cnt=2).
        @(negedge clk);
        btn_step = 1'b1;
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check_output("midreset_step_en", 32'(step_en), 32'd0);
        check_output("midreset_mode", 32'(mode), 32'd0);
        check_output("midreset_step_count", 32'(step_count), 32'd0);
        check_output("midreset_display", display, 32'd0);
        step_q.delete();
        mode_q.delete();
        exp_mode = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        exp_steps = 16'd1;
        step_q.push_back('{cyc + LAT, exp_steps});
        repeat (12) @(negedge clk);
        btn_step = 1'b0;
        repeat (10) @(negedge clk);
        check_output("midreset_final_count", 32'(step_count), 32'd1);

        check_output("step_q_drained", 32'(step_q.size()), 32'd0);
        check_output("mode_q_drained", 32'(mode_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_display_sel.md
# debug_display_sel

Upstream feeder for the seven-segment display driver in the single-cycle CPU board build. It debounces two push-buttons (single-step and display-mode), issues a one-cycle step enable to the CPU, and keeps a step counter. It also registers the 32-bit word the display driver shows, chosen by the current mode from PC, instruction, ALU result, or step count plus memory write data.

## Interface
Parameters:
- `DEB_CYCLES`, default 1_000_000: stable-level cycles required to accept a press or release (10 ms at 100 MHz). Minimum 2. Counter width is `$clog2(DEB_CYCLES)`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `btn_step`  in  1  raw step button, active-high, asynchronous to `clk`.
- `btn_mode`  in  1  raw mode button, active-high, asynchronous to `clk`.
- `pc`  in  32  current CPU PC.
- `instr`  in  32  current instruction.
- `alu_result`  in  32  current ALU output.
- `mem_wdata`  in  32  current data-memory write data.
- `step_en`  out  1  one-cycle pulse; the CPU advances one instruction per pulse.
- `mode`  out  2  current display mode.
- `step_count`  out  16  number of `step_en` pulses since reset; wraps.
- `display`  out  32  word to the seven-segment driver.

## Operation
- Each button feeds a two-flop synchronizer, then a debounce FSM with a counter `cnt`.
- Debounce FSM states and transitions:
  - IDLE: synced=1 → PRESS_CHK, `cnt`=0.
  - PRESS_CHK: synced=0 → IDLE. If `cnt`==DEB_CYCLES-1 → HELD and emit a pulse in that cycle. Otherwise `cnt`+1.
  - HELD: synced=0 → REL_CHK, `cnt`=0.
  - REL_CHK: synced=1 → HELD. If `cnt`==DEB_CYCLES-1 → IDLE. Otherwise `cnt`+1.
- Exactly one pulse per accepted press. A held button never repeats. Glitches shorter than DEB_CYCLES produce no pulse.
- Step pulse:
  - Registered into `step_en` on the next cycle.
  - `step_count` increments in the same cycle `step_en` is high.
  - 16'hFFFF wraps to 16'h0000.
- Mode pulse: `mode` increments 0→1→2→3→0.
- `display` is registered every cycle from `mode` and the source inputs as they are sampled that cycle:
  - mode 0 = `pc`
  - mode 1 = `instr`
  - mode 2 = `alu_result`
  - mode 3 = {`step_count`, `mem_wdata[15:0]`}
- Both pulses in the same cycle: both take effect independently. `mode` increments and `step_en` asserts in the same cycle.

## Timing
- Reset values: `step_en`=0, `mode`=0, `step_count`=0, `display`=0. Synchronizers are 0 and both FSMs are IDLE with `cnt`=0.
- Press latency: from the first `clk` edge where the raw button is sampled high to `step_en` high (or `mode` updated) is 2 (sync) + DEB_CYCLES + 1 cycles, provided the input stays stable.
- `display` lags any change of `mode`, sources or `step_count` by exactly one cycle.
- `step_en` is never high for two consecutive cycles.
- Reset asserted mid-count: all state clears immediately and asynchronously. A button still held after reset release must be re-accepted from IDLE, so it yields one pulse.

## Structure
- Shared package holds:
  - the debounce state encoding (IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, REL_CHK=2'd3);
  - the display mode constants (MODE_PC, MODE_INSTR, MODE_ALU, MODE_STEP).
- Sub-module `btn_debounce` (`clk`, `rst`, `btn_raw` → `press_pulse`; parameter `DEB_CYCLES`) contains the synchronizer and FSM. It is instantiated twice.
- The top level holds the mode counter, step counter, `step_en` register and display mux register.

## Test plan
All scenarios use DEB_CYCLES=4.
- Reset, then `btn_step` held high for 20 cycles → exactly one `step_en` pulse, 7 cycles after first sample; `step_count`=1.
- `btn_step` high for 3 cycles, low, repeated 5 times → no `step_en`; `step_count` stays 0.
- Four clean `btn_mode` presses with `pc`=32'h0000_0040, `instr`=32'h2008_0005, `alu_result`=32'h0000_000A → `display` steps through those three values, then {16'h0000, `mem_wdata[15:0]`}, then back to 32'h0000_0040.
- 65 536 step presses in mode 3 → `step_count` wraps to 0 and `display[31:16]`=16'h0000 one cycle later.
- Both buttons pressed in the same cycle → `step_en`=1 and `mode` increments in the same cycle.
- `rst` pulsed low while in PRESS_CHK with `cnt`=2 → all outputs 0 at once; a still-held button gives exactly one pulse 7 cycles after reset release.
